hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 16-bit, 4-stage pipeline (D, E, M, W) with 16 general registers.
- It drives the flush input of the decode-to-execute register and the stall inputs of the fetch and decode stages.
- It keeps a shadow record of every instruction in flight. For each instruction entering E it produces registered forwarding selects.
- It also counts stall cycles for performance debug.

Parameters:
- FWD_EN, 1, 1 = forwarding from M/W with load-use stall only; 0 = interlock until the producer retires.
- RF_BYPASS, 1, 1 = register file writes before it reads in the same cycle, so no hazard against W; 0 = W matches also hazard.
- ZERO_REG, 1, 1 = register 0 is hardwired and never creates a hazard.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- validD  in  1  decode stage holds a real instruction
- srcAddD1  in  4  decode source register 1
- srcAddD2  in  4  decode source register 2
- useSrcD1  in  1  source 1 is read
- useSrcD2  in  1  source 2 is read
- destAddD  in  4  decode destination register
- RegWriteC  in  1  decoded instruction writes a register
- MemToRegC  in  1  decoded instruction is a load
- memReadyM  in  1  memory stage complete; 0 freezes the whole pipeline
- stallF  out  1  hold PC
- stallD  out  1  hold decode register
- flushC  out  1  insert a bubble into the execute register
- fwdSelE1  out  2  E-stage operand 1 select: 00 register file, 01 M result, 10 W result
- fwdSelE2  out  2  same encoding for operand 2
- stallCount  out  16  saturating count of stall or freeze cycles

Behaviour:
- Shadow stages E, M, W: each holds {valid, dest[3:0], wr, load}. A stage is a producer if valid & wr, and, when ZERO_REG=1, dest != 0.
- Source match (source k vs stage X): useSrcDk & validD & X is a producer & srcAddDk == X.dest.

Combinational hazard detection (same cycle):
- freeze = ~memReadyM.
- If FWD_EN=1: luHaz = any source matches E and E.load = 1.
- If FWD_EN=0: luHaz = any source matches E or M, or W when RF_BYPASS=0.
- If FWD_EN=1 and RF_BYPASS=0, a match against W also raises luHaz.

Output priority:
- freeze: stallF = 1, stallD = 1, flushC = 0. All shadow stages, fwdSelE and stallCount+1 are held/updated as frozen; nothing advances.
- else luHaz: stallF = 1, stallD = 1, flushC = 1.
- else: all three outputs are 0.

Clocked update when not frozen:
- W <= M.
- M <= E.
- E <= bubble (valid 0) if luHaz or ~validD; otherwise {1, destAddD, RegWriteC, MemToRegC}.

fwdSelEk, registered with the E update:
- 01 if source k matches E and FWD_EN = 1.
- else 10 if source k matches M and FWD_EN = 1.
- else 00.
- Forced to 00 when a bubble is inserted.
- Held during freeze.
- M has priority over W because it is the newer value.

stallCount:
- Increments on every cycle where stallF = 1, counting both freeze and hazard cycles.
- Saturates at 16'hFFFF.

Reset (synchronous, active-high):
- All shadow valids = 0, fwdSelE1 = fwdSelE2 = 00, stallCount = 0.
- Reset has priority over freeze.
- While reset is high, combinational outputs reflect the cleared state: stallF = stallD = flushC = 0 unless memReadyM = 0.

Boundary and simultaneous-event cases:
- Both sources match different stages: each select resolves independently.
- Both sources match the same E load: a single 1-cycle stall.
- Load-use stall is exactly 1 cycle when FWD_EN = 1. The second cycle sees the load in M and forwards 10.
- Freeze arriving during a load-use stall: freeze wins; the hazard is re-evaluated when memReadyM returns.
- Reset mid-stall: the next cycle has no hazards.

Test Plan:
1. Forwarding ALU chain (FWD_EN=1):
   - Stimulus: D dest=3 wr=1, then the next instruction with src1=3.
   - Response: no stall; fwdSelE1 = 01 on the cycle the consumer is in E.
   - Stimulus: a consumer two instructions later.
   - Response: fwdSelE1 = 10.
2. Load-use:
   - Stimulus: load dest=5, followed by src2=5.
   - Response: one cycle of stallF = stallD = flushC = 1, then fwdSelE2 = 10, stallCount = 1.
3. Register 0:
   - Stimulus: load dest=0, followed by src1=0, with ZERO_REG=1.
   - Response: no stall, fwdSel = 00.
4. Memory freeze:
   - Stimulus: memReadyM = 0 for 3 cycles during a load-use hazard.
   - Response: flushC = 0 and shadows held for those 3 cycles, then 1 hazard cycle; stallCount = 4.
5. Interlock mode (FWD_EN=0, RF_BYPASS=1):
   - Stimulus: ALU dest=7, followed by src1=7.
   - Response: stall for 2 cycles (while the producer is in E and M); fwdSel is always 00.
6. Reset:
   - Stimulus: assert reset during a load-use stall.
   - Response: the next cycle shows all outputs 0, stallCount = 0, and the same decode inputs cause no stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for a 4-stage (D, E, M, W) 16-bit pipeline.
// A shadow copy of E/M/W tracks which instructions in flight will write which
// register. From it the block derives load-use / interlock stalls, the
// execute-register flush, registered operand forwarding selects for the
// instruction entering E, and a saturating stall-cycle counter.
module hazard_ctrl #(
   parameter bit FWD_EN    = 1'b1,
   parameter bit RF_BYPASS = 1'b1,
   parameter bit ZERO_REG  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        validD,
   input  logic [3:0]  srcAddD1,
   input  logic [3:0]  srcAddD2,
   input  logic        useSrcD1,
   input  logic        useSrcD2,
   input  logic [3:0]  destAddD,
   input  logic        RegWriteC,
   input  logic        MemToRegC,
   input  logic        memReadyM,
   output logic        stallF,
   output logic        stallD,
   output logic        flushC,
   output logic [1:0]  fwdSelE1,
   output logic [1:0]  fwdSelE2,
   output logic [15:0] stallCount
);

   // A stage produces a register value when it is valid, writes, and (with a
   // hardwired r0) does not target register 0.
   function automatic logic is_producer(input logic valid, input logic wr,
                                        input logic [3:0] dest);
      return valid & wr & ~(ZERO_REG & (dest == 4'd0));
   endfunction

   // A decode source depends on a stage when it is read and names its destination.
   function automatic logic src_match(input logic use_src, input logic [3:0] addr,
                                      input logic valid_d, input logic producer,
                                      input logic [3:0] dest);
      return use_src & valid_d & producer & (addr == dest);
   endfunction

   // The newest producer wins: E (result will sit in M) before M (result in W).
   function automatic logic [1:0] fwd_select(input logic bubble, input logic hit_e,
                                             input logic hit_m);
      logic [1:0] sel;
      if (bubble || !FWD_EN) begin
         sel = 2'b00;
      end else if (hit_e) begin
         sel = 2'b01;
      end else if (hit_m) begin
         sel = 2'b10;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Shadow stages. Only E needs the load flag: a load is a hazard only while
   // its data is still one stage away, after that it forwards like an ALU result.
   logic       e_valid_r, m_valid_r, w_valid_r;
   logic [3:0] e_dest_r,  m_dest_r,  w_dest_r;
   logic       e_wr_r,    m_wr_r,    w_wr_r;
   logic       e_load_r;

   logic e_prod_s, m_prod_s, w_prod_s;
   logic hit1_e_s, hit1_m_s, hit1_w_s;
   logic hit2_e_s, hit2_m_s, hit2_w_s;
   logic any_e_s, any_m_s, any_w_s;
   logic lu_fwd_s, lu_il_s, lu_haz_s;
   logic freeze_s, bubble_s;
   logic [1:0] sel1_nxt_s, sel2_nxt_s;

   assign e_prod_s = is_producer(e_valid_r, e_wr_r, e_dest_r);
   assign m_prod_s = is_producer(m_valid_r, m_wr_r, m_dest_r);
   assign w_prod_s = is_producer(w_valid_r, w_wr_r, w_dest_r);

   assign hit1_e_s = src_match(useSrcD1, srcAddD1, validD, e_prod_s, e_dest_r);
   assign hit1_m_s = src_match(useSrcD1, srcAddD1, validD, m_prod_s, m_dest_r);
   assign hit1_w_s = src_match(useSrcD1, srcAddD1, validD, w_prod_s, w_dest_r);
   assign hit2_e_s = src_match(useSrcD2, srcAddD2, validD, e_prod_s, e_dest_r);
   assign hit2_m_s = src_match(useSrcD2, srcAddD2, validD, m_prod_s, m_dest_r);
   assign hit2_w_s = src_match(useSrcD2, srcAddD2, validD, w_prod_s, w_dest_r);

   assign any_e_s = hit1_e_s | hit2_e_s;
   assign any_m_s = hit1_m_s | hit2_m_s;
   assign any_w_s = hit1_w_s | hit2_w_s;

   // Without write-before-read in the register file, a W producer is never visible.
   assign lu_fwd_s = (any_e_s & e_load_r) | (~RF_BYPASS & any_w_s);
   assign lu_il_s  = any_e_s | any_m_s | (~RF_BYPASS & any_w_s);

   assign freeze_s = ~memReadyM;
   assign bubble_s = lu_haz_s | ~validD;

   assign sel1_nxt_s = fwd_select(bubble_s, hit1_e_s, hit1_m_s);
   assign sel2_nxt_s = fwd_select(bubble_s, hit2_e_s, hit2_m_s);

   // Pick the hazard rule for the configured mode; reset masks any hazard.
   always_comb begin
      lu_haz_s = 1'b0;
      if (reset) begin
         lu_haz_s = 1'b0;
      end else if (FWD_EN) begin
         lu_haz_s = lu_fwd_s;
      end else begin
         lu_haz_s = lu_il_s;
      end
   end

   // Freeze holds everything without flushing; a hazard holds F/D and bubbles E.
   always_comb begin
      stallF = 1'b0;
      stallD = 1'b0;
      flushC = 1'b0;
      if (freeze_s) begin
         stallF = 1'b1;
         stallD = 1'b1;
         flushC = 1'b0;
      end else if (lu_haz_s) begin
         stallF = 1'b1;
         stallD = 1'b1;
         flushC = 1'b1;
      end else begin
         stallF = 1'b0;
         stallD = 1'b0;
         flushC = 1'b0;
      end
   end

   // Advance the shadow pipeline and forwarding selects unless memory freezes it.
   always_ff @(posedge clk) begin
      if (reset) begin
         e_valid_r <= 1'b0;
         e_dest_r  <= 4'd0;
         e_wr_r    <= 1'b0;
         e_load_r  <= 1'b0;
         m_valid_r <= 1'b0;
         m_dest_r  <= 4'd0;
         m_wr_r    <= 1'b0;
         w_valid_r <= 1'b0;
         w_dest_r  <= 4'd0;
         w_wr_r    <= 1'b0;
         fwdSelE1  <= 2'b00;
         fwdSelE2  <= 2'b00;
      end else if (memReadyM) begin
         w_valid_r <= m_valid_r;
         w_dest_r  <= m_dest_r;
         w_wr_r    <= m_wr_r;
         m_valid_r <= e_valid_r;
         m_dest_r  <= e_dest_r;
         m_wr_r    <= e_wr_r;
         e_valid_r <= ~bubble_s;
         e_dest_r  <= destAddD;
         e_wr_r    <= RegWriteC & ~bubble_s;
         e_load_r  <= MemToRegC & ~bubble_s;
         fwdSelE1  <= sel1_nxt_s;
         fwdSelE2  <= sel2_nxt_s;
      end
   end

   // Count every cycle fetch is held (freeze or hazard), saturating at all ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         stallCount <= 16'd0;
      end else if (stallF && (stallCount != 16'hFFFF)) begin
         stallCount <= stallCount + 16'd1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Three instances with different
// configurations share one stimulus stream; a distance-based reference model
// (how many stages ahead a producer is, and when its value becomes usable)
// predicts stalls, flushes, forwarding selects and the stall counter.
module tb_hazard_ctrl;

   // Config per instance: 0 = forwarding/bypass/r0, 1 = interlock, 2 = fwd without bypass, r0 live
   localparam bit [2:0] P_FWD = 3'b101;
   localparam bit [2:0] P_RFB = 3'b011;
   localparam bit [2:0] P_ZR  = 3'b011;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1;
   logic       validD = 1'b0;
   logic [3:0] srcAddD1 = 4'd0, srcAddD2 = 4'd0, destAddD = 4'd0;
   logic       useSrcD1 = 1'b0, useSrcD2 = 1'b0;
   logic       RegWriteC = 1'b0, MemToRegC = 1'b0, memReadyM = 1'b1;

   logic        sf_w [3];
   logic        sd_w [3];
   logic        fl_w [3];
   logic [1:0]  f1_w [3];
   logic [1:0]  f2_w [3];
   logic [15:0] cnt_w [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      hazard_ctrl #(.FWD_EN(P_FWD[g]), .RF_BYPASS(P_RFB[g]), .ZERO_REG(P_ZR[g])) u_dut (
         .clk(clk), .reset(reset), .validD(validD),
         .srcAddD1(srcAddD1), .srcAddD2(srcAddD2),
         .useSrcD1(useSrcD1), .useSrcD2(useSrcD2),
         .destAddD(destAddD), .RegWriteC(RegWriteC), .MemToRegC(MemToRegC),
         .memReadyM(memReadyM),
         .stallF(sf_w[g]), .stallD(sd_w[g]), .flushC(fl_w[g]),
         .fwdSelE1(f1_w[g]), .fwdSelE2(f2_w[g]), .stallCount(cnt_w[g]));
   end

   int n_vec = 0;
   int n_bad = 0;

   // Model: in-flight instructions indexed by distance ahead of decode (1=E, 2=M, 3=W)
   bit         md_valid [3][1:3];
   bit [3:0]   md_dest  [3][1:3];
   bit         md_wr    [3][1:3];
   bit         md_load  [3][1:3];
   bit         exp_haz  [3];
   bit         exp_sf   [3];
   bit         exp_fl   [3];
   bit [1:0]   exp_f1   [3];
   bit [1:0]   exp_f2   [3];
   bit [15:0]  exp_cnt  [3];

   function automatic bit is_prod(int c, int d);
      return md_valid[c][d] && md_wr[c][d] && !(P_ZR[c] && md_dest[c][d] == 4'd0);
   endfunction

   function automatic bit hits(int c, int d, bit u, logic [3:0] a);
      return u && validD && is_prod(c, d) && (a == md_dest[c][d]);
   endfunction

   // Is a producer's value still unusable by an instruction now in decode?
   function automatic bit must_wait(int c, int d);
      if (d == 3 && !P_RFB[c]) return 1'b1;
      if (P_FWD[c]) return (d == 1) && md_load[c][1];
      return d <= 2;
   endfunction

   function automatic bit model_haz(int c);
      if (reset) return 1'b0;
      for (int d = 1; d <= 3; d++)
         if ((hits(c, d, useSrcD1, srcAddD1) || hits(c, d, useSrcD2, srcAddD2)) && must_wait(c, d))
            return 1'b1;
      return 1'b0;
   endfunction

   // Nearest forwardable producer: distance 1 -> 01 (M result), distance 2 -> 10 (W result)
   function automatic bit [1:0] model_sel(int c, bit u, logic [3:0] a);
      if (!P_FWD[c]) return 2'b00;
      for (int d = 1; d <= 2; d++)
         if (hits(c, d, u, a)) return 2'(d);
      return 2'b00;
   endfunction

   task automatic drive(input bit v, input logic [3:0] a1, input bit u1, input logic [3:0] a2,
                        input bit u2, input logic [3:0] dst, input bit rw, input bit ld,
                        input bit rdy, input bit rst);
      @(negedge clk);
      validD = v; srcAddD1 = a1; useSrcD1 = u1; srcAddD2 = a2; useSrcD2 = u2;
      destAddD = dst; RegWriteC = rw; MemToRegC = ld; memReadyM = rdy; reset = rst;
      #1;
      for (int c = 0; c < 3; c++) begin
         exp_haz[c] = model_haz(c);
         exp_sf[c]  = !rdy || exp_haz[c];
         exp_fl[c]  = rdy && exp_haz[c];
      end
   endtask

   task automatic clk_edge();
      bit       bub [3];
      bit [1:0] n1 [3];
      bit [1:0] n2 [3];
      for (int c = 0; c < 3; c++) begin
         bub[c] = exp_haz[c] || !validD;
         n1[c]  = bub[c] ? 2'b00 : model_sel(c, useSrcD1, srcAddD1);
         n2[c]  = bub[c] ? 2'b00 : model_sel(c, useSrcD2, srcAddD2);
      end
      @(posedge clk);
      for (int c = 0; c < 3; c++) begin
         if (reset) begin
            for (int d = 1; d <= 3; d++) md_valid[c][d] = 1'b0;
            exp_f1[c] = 2'b00; exp_f2[c] = 2'b00; exp_cnt[c] = 16'd0;
         end else begin
            if (exp_sf[c] && exp_cnt[c] != 16'hFFFF) exp_cnt[c] = exp_cnt[c] + 16'd1;
            if (memReadyM) begin
               for (int d = 3; d >= 2; d--) begin
                  md_valid[c][d] = md_valid[c][d-1]; md_dest[c][d] = md_dest[c][d-1];
                  md_wr[c][d] = md_wr[c][d-1]; md_load[c][d] = md_load[c][d-1];
               end
               md_valid[c][1] = !bub[c]; md_dest[c][1] = destAddD;
               md_wr[c][1] = RegWriteC; md_load[c][1] = MemToRegC;
               exp_f1[c] = n1[c]; exp_f2[c] = n2[c];
            end
         end
      end
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      clk_edge();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         n_vec++;
         if ({sf_w[c], sd_w[c], fl_w[c], f1_w[c], f2_w[c], cnt_w[c]} !== 23'd0) begin
            n_bad++;
            $display("FAIL reset_state[%0d]: got stall/flush=%b%b%b sel=%b/%b cnt=%0d, want all zero",
                     c, sf_w[c], sd_w[c], fl_w[c], f1_w[c], f2_w[c], cnt_w[c]);
         end
      end
      // Freeze during reset still stalls, but reset keeps the counter clear
      drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      n_vec++;
      if ({sf_w[0], sd_w[0], fl_w[0]} !== 3'b110) begin
         n_bad++; $display("FAIL reset_freeze_out: got %b%b%b want 110", sf_w[0], sd_w[0], fl_w[0]);
      end
      clk_edge();
      n_vec++;
      if (cnt_w[0] !== 16'd0) begin
         n_bad++; $display("FAIL reset_freeze_cnt: got %0d want 0", cnt_w[0]);
      end
      reset = 1'b0;
   endtask

   task automatic test_fwd_chain();
      do_reset();
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
      clk_edge();
      drive(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0);
      n_vec++;
      if ({sf_w[0], sd_w[0], fl_w[0]} !== 3'b000) begin
         n_bad++; $display("FAIL fwd_no_stall: got %b%b%b want 000", sf_w[0], sd_w[0], fl_w[0]);
      end
      clk_edge();
      n_vec++;
      if (f1_w[0] !== 2'b01) begin
         n_bad++; $display("FAIL fwd_sel_m: got %b want 01", f1_w[0]);
      end
      drive(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0);
      clk_edge();
      n_vec++;
      if (f1_w[0] !== 2'b10) begin
         n_bad++; $display("FAIL fwd_sel_w: got %b want 10", f1_w[0]);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0);
      clk_edge();
      drive(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0);
      n_vec++;
      if ({sf_w[0], sd_w[0], fl_w[0]} !== 3'b111) begin
         n_bad++; $display("FAIL lu_stall: got %b%b%b want 111", sf_w[0], sd_w[0], fl_w[0]);
      end
      clk_edge();
      drive(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0);
      n_vec++;
      if ({sf_w[0], sd_w[0], fl_w[0]} !== 3'b000) begin
         n_bad++; $display("FAIL lu_release: got %b%b%b want 000", sf_w[0], sd_w[0], fl_w[0]);
      end
      clk_edge();
      n_vec++;
      if ({f2_w[0], cnt_w[0]} !== {2'b10, 16'd1}) begin
         n_bad++; $display("FAIL lu_after: got sel2=%b cnt=%0d want 10 cnt=1", f2_w[0], cnt_w[0]);
      end
   endtask

   task automatic test_both_sources();
      // Both sources on the same load: a single stall, then both forward from W
      do_reset();
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0);
      clk_edge();
      drive(1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      clk_edge();
      drive(1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      clk_edge();
      n_vec++;
      if ({f1_w[0], f2_w[0], cnt_w[0]} !== {2'b10, 2'b10, 16'd1}) begin
         n_bad++; $display("FAIL both_same_load: got %b/%b cnt=%0d want 10/10 cnt=1", f1_w[0], f2_w[0], cnt_w[0]);
      end
      // Sources matching different stages resolve independently
      do_reset();
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
      clk_edge();
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0);
      clk_edge();
      drive(1'b1, 4'd2, 1'b1, 4'd4, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      clk_edge();
      n_vec++;
      if ({f1_w[0], f2_w[0]} !== {2'b10, 2'b01}) begin
         n_bad++; $display("FAIL both_diff_stage: got %b/%b want 10/01", f1_w[0], f2_w[0]);
      end
   endtask

   task automatic test_zero_reg();
      do_reset();
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
      clk_edge();
      drive(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0);
      n_vec++;
      if ({sf_w[0], sd_w[0], fl_w[0]} !== 3'b000) begin
         n_bad++; $display("FAIL r0_no_stall: got %b%b%b want 000", sf_w[0], sd_w[0], fl_w[0]);
      end
      n_vec++;
      if ({sf_w[2], sd_w[2], fl_w[2]} !== 3'b111) begin
         n_bad++; $display("FAIL r0_live_stall: got %b%b%b want 111", sf_w[2], sd_w[2], fl_w[2]);
      end
      clk_edge();
      n_vec++;
      if (f1_w[0] !== 2'b00) begin
         n_bad++; $display("FAIL r0_sel: got %b want 00", f1_w[0]);
      end
   endtask

   task automatic test_freeze();
      do_reset();
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0);
      clk_edge();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
         n_vec++;
         if ({sf_w[0], sd_w[0], fl_w[0]} !== 3'b110) begin
            n_bad++; $display("FAIL frz_out[%0d]: got %b%b%b want 110", i, sf_w[0], sd_w[0], fl_w[0]);
         end
         clk_edge();
         n_vec++;
         if ({f2_w[0], cnt_w[0]} !== {2'b00, 16'(i + 1)}) begin
            n_bad++; $display("FAIL frz_hold[%0d]: got sel2=%b cnt=%0d want 00 cnt=%0d", i, f2_w[0], cnt_w[0], i + 1);
         end
      end
      drive(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0);
      n_vec++;
      if ({sf_w[0], sd_w[0], fl_w[0]} !== 3'b111) begin
         n_bad++; $display("FAIL frz_then_haz: got %b%b%b want 111", sf_w[0], sd_w[0], fl_w[0]);
      end
      clk_edge();
      drive(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0);
      clk_edge();
      n_vec++;
      if ({f2_w[0], cnt_w[0]} !== {2'b10, 16'd4}) begin
         n_bad++; $display("FAIL frz_final: got sel2=%b cnt=%0d want 10 cnt=4", f2_w[0], cnt_w[0]);
      end
   endtask

   task automatic test_interlock();
      do_reset();
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0);
      clk_edge();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0);
         n_vec++;
         if ({sf_w[1], sd_w[1], fl_w[1]} !== ((i < 2) ? 3'b111 : 3'b000)) begin
            n_bad++; $display("FAIL il_stall[%0d]: got %b%b%b want %b", i, sf_w[1], sd_w[1], fl_w[1],
                              (i < 2) ? 3'b111 : 3'b000);
         end
         clk_edge();
         n_vec++;
         if (f1_w[1] !== 2'b00) begin
            n_bad++; $display("FAIL il_sel[%0d]: got %b want 00", i, f1_w[1]);
         end
      end
      n_vec++;
      if (cnt_w[1] !== 16'd2) begin
         n_bad++; $display("FAIL il_cnt: got %0d want 2", cnt_w[1]);
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0);
      clk_edge();
      drive(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      clk_edge();
      drive(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0, 1'b1, 1'b1);
      n_vec++;
      if ({sf_w[0], sd_w[0], fl_w[0]} !== 3'b000) begin
         n_bad++; $display("FAIL rst_masks_haz: got %b%b%b want 000", sf_w[0], sd_w[0], fl_w[0]);
      end
      clk_edge();
      n_vec++;
      if ({f1_w[0], f2_w[0], cnt_w[0]} !== 20'd0) begin
         n_bad++; $display("FAIL rst_clears: got %b/%b cnt=%0d want 00/00 cnt=0", f1_w[0], f2_w[0], cnt_w[0]);
      end
      drive(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0);
      n_vec++;
      if ({sf_w[0], sd_w[0], fl_w[0]} !== 3'b000) begin
         n_bad++; $display("FAIL rst_next_clean: got %b%b%b want 000", sf_w[0], sd_w[0], fl_w[0]);
      end
      clk_edge();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 99) < 85), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
               ($urandom_range(0, 99) < 70), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 99) < 85), ($urandom_range(0, 49) == 0));
         for (int c = 0; c < 3; c++) begin
            n_vec++;
            if ({sf_w[c], sd_w[c], fl_w[c]} !== {exp_sf[c], exp_sf[c], exp_fl[c]}) begin
               n_bad++; $display("FAIL rnd_out[%0d] cyc %0d: got %b%b%b want %b%b%b", c, i,
                                 sf_w[c], sd_w[c], fl_w[c], exp_sf[c], exp_sf[c], exp_fl[c]);
            end
         end
         clk_edge();
         for (int c = 0; c < 3; c++) begin
            n_vec++;
            if ({f1_w[c], f2_w[c], cnt_w[c]} !== {exp_f1[c], exp_f2[c], exp_cnt[c]}) begin
               n_bad++; $display("FAIL rnd_reg[%0d] cyc %0d: got %b/%b cnt=%0d want %b/%b cnt=%0d", c, i,
                                 f1_w[c], f2_w[c], cnt_w[c], exp_f1[c], exp_f2[c], exp_cnt[c]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_fwd_chain();
      test_load_use();
      test_both_sources();
      test_zero_reg();
      test_freeze();
      test_interlock();
      test_reset_mid_stall();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
